// File: rtl/bch_key_sched.sv
// Round-robin scheduler that shares one bch_key solver among N syndrome sources.
// All-zero syndrome jobs bypass the solver and produce an empty locator at once.
module bch_key_sched #(
   parameter  int M  = 4,
   parameter  int T  = 3,
   parameter  int N  = 3,
   localparam int SW = (2*T-1)*M,
   localparam int EW = $clog2(T+1),
   localparam int IW = $clog2(N),
   localparam int SG = M*(T+1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic [N*SW-1:0] req_syndromes,
   output logic [N-1:0]    gnt,
   output logic            key_start,
   output logic [SW-1:0]   key_syndromes,
   output logic            key_accepted,
   input  logic            key_busy,
   input  logic            key_done,
   input  logic [SG-1:0]   key_sigma,
   input  logic [EW-1:0]   key_err_count,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [IW-1:0]   out_id,
   output logic [SG-1:0]   out_sigma,
   output logic [EW-1:0]   out_err_count
);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   state_t        state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] id_q;
   logic [IW-1:0] gnt_idx;
   logic [IW:0]   idx;
   logic          grant_ok;
   logic          found;
   logic [SW-1:0] sel_syn;
   logic          sel_zero;

   // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
   always_comb begin
      gnt      = '0;
      gnt_idx  = '0;
      idx      = '0;
      found    = 1'b0;
      grant_ok = (state == IDLE) && (|req) && !key_busy && !out_valid;
      if (grant_ok) begin
         for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
            if (!found && req[idx]) begin
               found        = 1'b1;
               gnt[idx]     = 1'b1;
               gnt_idx      = idx[IW-1:0];
            end
         end
      end
   end

   assign sel_syn  = req_syndromes[gnt_idx*SW +: SW];
   assign sel_zero = ~|sel_syn;

   // A done outside START/WAIT is a leftover from an aborted job: acknowledge and drop it.
   assign key_accepted = key_done;

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ptr           <= '0;
         id_q          <= '0;
         key_start     <= 1'b0;
         key_syndromes <= '0;
         out_valid     <= 1'b0;
         out_id        <= '0;
         out_sigma     <= '0;
         out_err_count <= '0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_ok) begin
                  ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + IW'(1);
                  if (sel_zero) begin
                     out_valid     <= 1'b1;
                     out_id        <= gnt_idx;
                     out_sigma     <= '0;
                     out_err_count <= '0;
                  end else begin
                     key_syndromes <= sel_syn;
                     id_q          <= gnt_idx;
                     key_start     <= 1'b1;
                     state         <= START;
                  end
               end
            end
            START, WAIT: begin
               key_start <= 1'b0;
               if (key_done) begin
                  out_valid     <= 1'b1;
                  out_id        <= id_q;
                  out_sigma     <= key_sigma;
                  out_err_count <= key_err_count;
                  state         <= IDLE;
               end else begin
                  state <= WAIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bch_key_sched.sv
// Scoreboard bench for bch_key_sched with a behavioural fixed-latency solver model.
module tb_bch_key_sched;
   localparam int M = 4, T = 3, N = 3;
   localparam int SW = (2*T-1)*M, EW = $clog2(T+1), IW = $clog2(N), SG = M*(T+1);
   localparam int LAT = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*SW-1:0] req_syndromes;
   logic [N-1:0]    gnt;
   logic            key_start;
   logic [SW-1:0]   key_syndromes;
   logic            key_accepted;
   logic            key_busy;
   logic            key_done;
   logic [SG-1:0]   key_sigma;
   logic [EW-1:0]   key_err_count;
   logic            out_valid;
   logic            out_ready;
   logic [IW-1:0]   out_id;
   logic [SG-1:0]   out_sigma;
   logic [EW-1:0]   out_err_count;

   logic busy_force, model_busy;
   assign key_busy = busy_force | model_busy;

   bch_key_sched #(.M(M), .T(T), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_syndromes(req_syndromes), .gnt(gnt),
      .key_start(key_start), .key_syndromes(key_syndromes), .key_accepted(key_accepted),
      .key_busy(key_busy), .key_done(key_done), .key_sigma(key_sigma),
      .key_err_count(key_err_count), .out_valid(out_valid), .out_ready(out_ready),
      .out_id(out_id), .out_sigma(out_sigma), .out_err_count(out_err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IW-1:0] id;
      logic [SG-1:0] sigma;
      logic [EW-1:0] err;
   } exp_t;

   exp_t sb[$];
   int   grant_log[$];
   int   start_count = 0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [SG-1:0] model_sigma(input logic [SW-1:0] s);
      return s[SW-1:4] ^ 16'h0001;
   endfunction

   function automatic logic [EW-1:0] model_err(input logic [SW-1:0] s);
      return s[EW-1:0];
   endfunction

   // Solver: done LAT cycles after the start cycle, busy in between.
   initial begin : solver
      int cnt;
      logic [SW-1:0] lat_syn;
      cnt = 0; lat_syn = '0;
      model_busy = 1'b0; key_done = 1'b0; key_sigma = '0; key_err_count = '0;
      forever begin
         @(posedge clk); #1;
         key_done = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               key_done      = 1'b1;
               model_busy    = 1'b0;
               key_sigma     = model_sigma(lat_syn);
               key_err_count = model_err(lat_syn);
            end
         end
         if (key_start) begin
            cnt = LAT; model_busy = 1'b1; lat_syn = key_syndromes;
         end
      end
   end

   // Monitor: pushes expectations on grants, pops and compares on output handshakes.
   exp_t          e;
   logic [SW-1:0] gsyn;
   always @(negedge clk) begin
      if (rst_n) begin
         if (key_start) start_count++;
         if (gnt != '0) check("gnt_onehot", $countones(gnt), 1);
         for (int i = 0; i < N; i++) begin
            if (gnt[i] && req[i]) begin
               grant_log.push_back(i);
               gsyn = req_syndromes[i*SW +: SW];
               e.id = IW'(i);
               e.sigma = (gsyn == '0) ? '0 : model_sigma(gsyn);
               e.err   = (gsyn == '0) ? '0 : model_err(gsyn);
               sb.push_back(e);
            end
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) check("unexpected_out", 1, 0);
            else begin
               e = sb.pop_front();
               check("out_id", out_id, e.id);
               check("out_sigma", out_sigma, e.sigma);
               check("out_err_count", out_err_count, e.err);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0: return key_start;
         1: return key_done;
         default: return out_valid;
      endcase
   endfunction

   task automatic wait_sig(input string tag, input int sel, output int at);
      at = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (sig(sel)) begin at = cyc; break; end
      end
      if (at < 0) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic drain(input string tag);
      for (int n = 0; n < 60 && (sb.size() != 0 || out_valid); n++) @(negedge clk);
      check(tag, sb.size(), 0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_gnt"}, gnt, 0);
      check({tag, "_start"}, key_start, 0);
      check({tag, "_acc"}, key_accepted, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_ksyn"}, key_syndromes, 0);
      check({tag, "_id"}, out_id, 0);
      check({tag, "_sigma"}, out_sigma, 0);
      check({tag, "_err"}, out_err_count, 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int g, at, s0;
      rst_n = 1'b0; req = '0; req_syndromes = '0; out_ready = 1'b1; busy_force = 1'b0;
      @(negedge clk);
      check_reset_vals("rst");
      tick(); rst_n = 1'b1;

      // Single nonzero job from source 1.
      tick(); req = 3'b010; req_syndromes[1*SW +: SW] = 20'h00001;
      @(negedge clk); g = cyc;
      check("t1_gnt", gnt, 3'b010);
      tick(); req = '0;
      wait_sig("t1_start", 0, at); check("t1_start_lat", at - g, 1);
      wait_sig("t1_done", 1, at);  check("t1_accepted", key_accepted, 1);
      wait_sig("t1_valid", 2, at); check("t1_valid_lat", at - g, 7);
      check("t1_id", out_id, 1);
      check("t1_err", out_err_count, 1);
      drain("t1_drain");

      // Zero-syndrome bypass from source 2.
      s0 = start_count;
      tick(); req = 3'b100; req_syndromes[2*SW +: SW] = '0;
      @(negedge clk); g = cyc;
      check("t2_gnt", gnt, 3'b100);
      tick(); req = '0;
      wait_sig("t2_valid", 2, at); check("t2_valid_lat", at - g, 1);
      check("t2_id", out_id, 2);
      check("t2_sigma", out_sigma, 0);
      check("t2_err", out_err_count, 0);
      repeat (3) @(negedge clk);
      check("t2_no_start", start_count, s0);
      drain("t2_drain");

      // Fairness with all three requesting, mixed bypass and solver jobs.
      grant_log.delete();
      tick(); req = 3'b111;
      req_syndromes = '0; req_syndromes[1*SW +: SW] = 20'h12345;
      for (int n = 0; n < 200 && grant_log.size() < 6; n++) begin @(negedge clk); #1; end
      tick(); req = '0;
      if (grant_log.size() < 6) check("t3_grant_count", grant_log.size(), 6);
      else for (int k = 0; k < 6; k++) check($sformatf("t3_order%0d", k), grant_log[k], k % 3);
      drain("t3_drain");

      // Backpressure: result held while source 0 keeps requesting.
      out_ready = 1'b0;
      tick(); req = 3'b001; req_syndromes[0 +: SW] = 20'h0ABC5;
      @(negedge clk); g = cyc;
      check("t4_gnt", gnt, 3'b001);
      tick(); req_syndromes[0 +: SW] = '0;
      wait_sig("t4_valid", 2, at);
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         check("t4_hold_gnt", gnt, 0);
         check("t4_hold_valid", out_valid, 1);
         check("t4_hold_id", out_id, 0);
         check("t4_hold_sigma", out_sigma, model_sigma(20'h0ABC5));
         check("t4_hold_err", out_err_count, model_err(20'h0ABC5));
      end
      tick(); out_ready = 1'b1;
      @(negedge clk); check("t4_handshake", out_valid, 1);
      tick(); #0;
      @(negedge clk); check("t4_regrant", gnt, 3'b001);
      tick(); req = '0;
      drain("t4_drain");

      // Reset during WAIT, then a stray done from the solver.
      tick(); req = 3'b010; req_syndromes[1*SW +: SW] = 20'h00003;
      @(negedge clk); check("t5_gnt", gnt, 3'b010);
      tick(); req = '0;
      tick(); tick();
      rst_n = 1'b0; #1;
      check_reset_vals("t5_rst");
      tick(); rst_n = 1'b1; sb.delete();
      wait_sig("t5_stray", 1, at);
      check("t5_stray_acc", key_accepted, 1);
      check("t5_stray_valid", out_valid, 0);
      for (int n = 0; n < 4; n++) begin
         @(negedge clk); check("t5_no_valid", out_valid, 0);
      end
      tick(); req = 3'b100; req_syndromes[2*SW +: SW] = 20'h0F0F2;
      @(negedge clk); check("t5_gnt_after", gnt, 3'b100);
      tick(); req = '0;
      wait_sig("t5_valid", 2, at); check("t5_id", out_id, 2);
      drain("t5_drain");

      // Solver busy holds off grants.
      busy_force = 1'b1;
      tick(); req = 3'b001; req_syndromes[0 +: SW] = 20'h00042;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk); check("t6_busy_gnt", gnt, 0);
      end
      tick(); busy_force = 1'b0;
      @(negedge clk); check("t6_gnt", gnt, 3'b001);
      tick(); req = '0;
      wait_sig("t6_valid", 2, at); check("t6_id", out_id, 0);
      drain("t6_drain");

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
